// File: rtl/audio_frame_packer.sv
// Mic sample deviation accumulator that publishes NUM_BARS loudness bars per frame
// into a ping-pong buffer. Optional macro OVERRUN_CNT_EN adds a dropped-sample counter.
module audio_frame_packer #(
    parameter int unsigned SAMPLE_W = 12,
    parameter int unsigned BAR_W    = 18,
    parameter int unsigned NUM_BARS = 16,
    parameter int unsigned DECIM    = 64
) (
    input  logic                        clk_25,
    input  logic                        rst,
    input  logic [SAMPLE_W-1:0]         sample_in,
    input  logic                        sample_valid,
    input  logic                        rd_lock,
    input  logic [$clog2(NUM_BARS)-1:0] rd_addr,
    output logic [BAR_W-1:0]            rd_data,
    output logic                        frame_ready,
    input  logic                        frame_ack
`ifdef OVERRUN_CNT_EN
    ,
    output logic [7:0]                  overrun_cnt
`endif
);

    localparam int unsigned IDX_W = $clog2(NUM_BARS);
    localparam int unsigned CNT_W = $clog2(DECIM);
    localparam logic [SAMPLE_W-1:0] MID = {1'b1, {(SAMPLE_W-1){1'b0}}};

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t             state;
    logic [BAR_W-1:0]   bank [2][NUM_BARS];
    logic               rsel;
    logic [BAR_W-1:0]   acc;
    logic [CNT_W-1:0]   sample_cnt;
    logic [IDX_W-1:0]   bar_idx;

    logic [SAMPLE_W-1:0] dev_c;
    logic [BAR_W:0]      sum_c;
    logic [BAR_W-1:0]    acc_next_c;

    // Distance of the offset-binary sample from mid-scale, then saturating add.
    always_comb begin
        dev_c      = (sample_in >= MID) ? (sample_in - MID) : (MID - sample_in);
        sum_c      = {1'b0, acc} + (BAR_W+1)'(dev_c);
        acc_next_c = sum_c[BAR_W] ? {BAR_W{1'b1}} : sum_c[BAR_W-1:0];
    end

    always_ff @(posedge clk_25) begin
        if (rst) begin
            state       <= FILL;
            rsel        <= 1'b0;
            acc         <= '0;
            sample_cnt  <= '0;
            bar_idx     <= '0;
            rd_data     <= '0;
            frame_ready <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < int'(NUM_BARS); i++) begin
                    bank[b][i] <= '0;
                end
            end
`ifdef OVERRUN_CNT_EN
            overrun_cnt <= '0;
`endif
        end else begin
            rd_data <= bank[rsel][rd_addr];

            if (frame_ack && frame_ready) begin
                frame_ready <= 1'b0;
            end

            case (state)
                FILL: begin
                    if (sample_valid) begin
                        if (sample_cnt == CNT_W'(DECIM - 1)) begin
                            bank[~rsel][bar_idx] <= acc_next_c;
                            acc        <= '0;
                            sample_cnt <= '0;
                            bar_idx    <= bar_idx + IDX_W'(1);
                            if (bar_idx == IDX_W'(NUM_BARS - 1)) begin
                                state <= FULL;
                            end
                        end else begin
                            acc        <= acc_next_c;
                            sample_cnt <= sample_cnt + CNT_W'(1);
                        end
                    end
                end
                FULL: begin
`ifdef OVERRUN_CNT_EN
                    if (sample_valid && (overrun_cnt != 8'hFF)) begin
                        overrun_cnt <= overrun_cnt + 8'd1;
                    end
`endif
                    // Swap only when the consumer is not mid-read; swap beats a same-cycle ack.
                    if (!rd_lock) begin
                        rsel        <= ~rsel;
                        frame_ready <= 1'b1;
                        state       <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_audio_frame_packer.sv
// Directed bench for audio_frame_packer: frame-level reference model plus literal checks.
module tb_audio_frame_packer;

    localparam int NB    = 16;
    localparam int DEC   = 64;
    localparam int MAXV  = (1 << 18) - 1;

    logic        clk_25 = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] sample_in = '0;
    logic        sample_valid = 1'b0;
    logic        rd_lock = 1'b0;
    logic [3:0]  rd_addr = '0;
    logic [17:0] rd_data;
    logic        frame_ready;
    logic        frame_ack = 1'b0;
`ifdef OVERRUN_CNT_EN
    logic [7:0]  overrun_cnt;
`endif

    int total = 0;
    int bad = 0;

    audio_frame_packer dut (
        .clk_25      (clk_25),
        .rst         (rst),
        .sample_in   (sample_in),
        .sample_valid(sample_valid),
        .rd_lock     (rd_lock),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .frame_ready (frame_ready),
        .frame_ack   (frame_ack)
`ifdef OVERRUN_CNT_EN
        ,
        .overrun_cnt (overrun_cnt)
`endif
    );

    always #20 clk_25 = ~clk_25;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int dev(input int v);
        return (v >= 2048) ? v - 2048 : 2048 - v;
    endfunction

    // Reference model: whole frames built from accepted samples, copied on publish.
    int  m_rbank [NB];
    int  m_frame [NB];
    int  m_sum, m_n, m_ovr, m_rdata;
    bit  m_ready, m_pend, m_init;

    always @(posedge clk_25) begin
        if (rst) begin
            m_init = 1'b1;
            for (int i = 0; i < NB; i++) begin
                m_rbank[i] = 0;
                m_frame[i] = 0;
            end
            m_sum = 0; m_n = 0; m_ovr = 0; m_rdata = 0;
            m_ready = 1'b0; m_pend = 1'b0;
        end else if (m_init) begin
            m_rdata = m_rbank[rd_addr];
            if (frame_ack) m_ready = 1'b0;
            if (m_pend) begin
                if (sample_valid && m_ovr < 255) m_ovr++;
                if (!rd_lock) begin
                    m_rbank = m_frame;
                    m_ready = 1'b1;
                    m_pend  = 1'b0;
                end
            end else if (sample_valid) begin
                m_sum += dev(int'(sample_in));
                m_n++;
                if (m_n % DEC == 0) begin
                    m_frame[m_n / DEC - 1] = (m_sum > MAXV) ? MAXV : m_sum;
                    m_sum = 0;
                    if (m_n == NB * DEC) begin
                        m_pend = 1'b1;
                        m_n = 0;
                    end
                end
            end
        end
        if (m_init) begin
            #1;
            chk("model rd_data", 32'(rd_data), 32'(m_rdata));
            chk("model frame_ready", 32'(frame_ready), 32'(m_ready));
`ifdef OVERRUN_CNT_EN
            chk("model overrun_cnt", 32'(overrun_cnt), 32'(m_ovr));
`endif
        end
    end

    task automatic strobe(input int v);
        @(negedge clk_25);
        sample_in = 12'(v);
        sample_valid = 1'b1;
        @(negedge clk_25);
        sample_valid = 1'b0;
    endtask

    // mode 0: constant v; mode 1: alternate 0/4095; mode 2: bar k gets 2048+10k
    task automatic feed(input int n, input int mode, input int v);
        for (int i = 0; i < n; i++) begin
            case (mode)
                1:       strobe((i % 2 == 0) ? 0 : 4095);
                2:       strobe(2048 + 10 * ((i / DEC) % NB));
                default: strobe(v);
            endcase
        end
    endtask

    task automatic rd(input int addr, input int exp, input string nm);
        @(negedge clk_25);
        rd_addr = 4'(addr);
        @(posedge clk_25);
        #2;
        chk(nm, 32'(rd_data), 32'(exp));
    endtask

    task automatic pulse_ack();
        @(negedge clk_25);
        frame_ack = 1'b1;
        @(negedge clk_25);
        frame_ack = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_25);
        rst = 1'b1;
        @(negedge clk_25);
        @(negedge clk_25);
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        #2;
        chk("reset frame_ready", 32'(frame_ready), 32'd0);
        chk("reset rd_data", 32'(rd_data), 32'd0);

        // 1: mid-scale samples give zero bars; ready one cycle after last sample
        feed(NB * DEC, 0, 2048);
        chk("t1 ready before swap", 32'(frame_ready), 32'd0);
        @(posedge clk_25);
        #2;
        chk("t1 ready after swap", 32'(frame_ready), 32'd1);
        for (int k = 0; k < NB; k++) rd(k, 0, "t1 bar");

        // 2: full-swing alternation
        feed(NB * DEC, 1, 0);
        repeat (3) @(negedge clk_25);
        rd(0, 131040, "t2 bar0");
        rd(9, 131040, "t2 bar9");
        rd(15, 131040, "t2 bar15");

        // 3: ramp per bar, twice
        for (int rep = 0; rep < 2; rep++) begin
            feed(NB * DEC, 2, 0);
            repeat (3) @(negedge clk_25);
            rd(0, 0, "t3 bar0");
            rd(5, 3200, "t3 bar5");
            rd(15, 9600, "t3 bar15");
        end
        pulse_ack();
        #2;
        chk("t3 ack clears", 32'(frame_ready), 32'd0);

        // 4: lock held across frame completion; samples during lock dropped
        @(negedge clk_25);
        rd_lock = 1'b1;
        feed(NB * DEC, 0, 2058);
        feed(100, 0, 4095);
        chk("t4 ready held off", 32'(frame_ready), 32'd0);
        rd(3, 1920, "t4 old bank stable");
`ifdef OVERRUN_CNT_EN
        chk("t4 overrun", 32'(overrun_cnt), 32'd100);
`endif
        @(negedge clk_25);
        rd_lock = 1'b0;
        #2;
        chk("t4 ready before release edge", 32'(frame_ready), 32'd0);
        @(posedge clk_25);
        #2;
        chk("t4 ready after release", 32'(frame_ready), 32'd1);
        rd(3, 640, "t4 new bank");

        // 5: ack coincident with swap loses; a lone ack then clears
        feed(NB * DEC, 0, 2049);
        frame_ack = 1'b1;
        @(negedge clk_25);
        frame_ack = 1'b0;
        chk("t5 swap beats ack", 32'(frame_ready), 32'd1);
        pulse_ack();
        chk("t5 lone ack", 32'(frame_ready), 32'd0);
        pulse_ack();
        chk("t5 ack when idle", 32'(frame_ready), 32'd0);
        rd(7, 64, "t5 bar7");

        // 6: reset mid-frame discards everything
        feed(500, 0, 4000);
        do_reset();
        #2;
        chk("t6 ready after reset", 32'(frame_ready), 32'd0);
        for (int k = 0; k < NB; k++) rd(k, 0, "t6 cleared bar");
        feed(NB * DEC - 1, 0, 2050);
        repeat (3) @(negedge clk_25);
        chk("t6 ready needs full frame", 32'(frame_ready), 32'd0);
        feed(1, 0, 2050);
        @(posedge clk_25);
        #2;
        chk("t6 ready after fresh frame", 32'(frame_ready), 32'd1);
        rd(15, 128, "t6 bar15");

        repeat (2) @(negedge clk_25);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
